// File: rtl/ps2_host_tx.sv
// ps2_host_tx: PS/2 host-to-device command transmitter.
// Drives open-drain clock/data enables; the device supplies the bit clock.
module ps2_host_tx #(
  parameter int INHIBIT_CYCLES = 6000,
  parameter int REQ_CYCLES     = 250,
  parameter int TIMEOUT_CYCLES = 750000
) (
  input  logic       clk_chipset,
  input  logic       rst_n,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       busy,
  output logic       done,
  output logic       err,
  input  logic       ps2_clk_in,
  input  logic       ps2_data_in,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe
);

  localparam int PH_MAX =
    (INHIBIT_CYCLES > REQ_CYCLES) ? INHIBIT_CYCLES : REQ_CYCLES;
  localparam int PW = $clog2(PH_MAX + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [PW-1:0] INH_LAST = PW'(INHIBIT_CYCLES - 1);
  localparam logic [PW-1:0] REQ_LAST = PW'(REQ_CYCLES - 1);
  localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT_CYCLES - 1);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_INH  = 3'd1;
  localparam logic [2:0] S_REQ  = 3'd2;
  localparam logic [2:0] S_SEND = 3'd3;
  localparam logic [2:0] S_ACK  = 3'd4;
  localparam logic [2:0] S_WAIT = 3'd5;

  logic [2:0]    state_q, state_d;
  logic [PW-1:0] pcnt_q, pcnt_d;
  logic [TW-1:0] tcnt_q, tcnt_d;
  logic [3:0]    bcnt_q, bcnt_d;
  logic [7:0]    data_q, data_d;
  logic          par_q, par_d;
  logic          clk_oe_q, clk_oe_d;
  logic          data_oe_q, data_oe_d;
  logic          done_q, done_d;
  logic          err_q, err_d;

  // [1] is the synced level, [2] its previous value for edge detect
  logic [2:0]    ck_sync_q;
  logic [1:0]    dt_sync_q;
  logic          ck_s, dt_s, fe, timing;

  assign ck_s = ck_sync_q[1];
  assign dt_s = dt_sync_q[1];
  assign fe   = ck_sync_q[2] & ~ck_sync_q[1];

  assign timing = (state_q == S_SEND) |
                  (state_q == S_ACK)  |
                  (state_q == S_WAIT);

  always_comb begin
    state_d   = state_q;
    pcnt_d    = pcnt_q;
    tcnt_d    = tcnt_q;
    bcnt_d    = bcnt_q;
    data_d    = data_q;
    par_d     = par_q;
    data_oe_d = data_oe_q;
    done_d    = 1'b0;
    err_d     = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (tx_valid) begin
          data_d  = tx_data;
          par_d   = ~^tx_data;
          pcnt_d  = '0;
          tcnt_d  = '0;
          bcnt_d  = '0;
          state_d = S_INH;
        end
      end
      S_INH: begin
        if (pcnt_q == INH_LAST) begin
          pcnt_d    = '0;
          data_oe_d = 1'b1;
          state_d   = S_REQ;
        end else begin
          pcnt_d = pcnt_q + 1'b1;
        end
      end
      S_REQ: begin
        if (pcnt_q == REQ_LAST) begin
          pcnt_d  = '0;
          tcnt_d  = '0;
          state_d = S_SEND;
        end else begin
          pcnt_d = pcnt_q + 1'b1;
        end
      end
      S_SEND: begin
        tcnt_d = tcnt_q + 1'b1;
        if (fe) begin
          bcnt_d = bcnt_q + 1'b1;
          if (bcnt_q < 4'd8) begin
            data_oe_d = ~data_q[bcnt_q[2:0]];
          end else if (bcnt_q == 4'd8) begin
            data_oe_d = ~par_q;
          end else begin
            data_oe_d = 1'b0;
            state_d   = S_ACK;
          end
        end
      end
      S_ACK: begin
        tcnt_d = tcnt_q + 1'b1;
        if (fe) begin
          if (!dt_s) begin
            state_d = S_WAIT;
          end else begin
            err_d   = 1'b1;
            state_d = S_IDLE;
          end
        end
      end
      S_WAIT: begin
        tcnt_d = tcnt_q + 1'b1;
        if (ck_s && dt_s) begin
          done_d  = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // a silent or stuck device must not hold the bus forever
    if (timing && (tcnt_q == TO_LAST)) begin
      done_d  = 1'b0;
      err_d   = 1'b1;
      state_d = S_IDLE;
    end

    if ((state_d != S_REQ) && (state_d != S_SEND)) begin
      data_oe_d = 1'b0;
    end
    clk_oe_d = (state_d == S_INH) | (state_d == S_REQ);
  end

  always_ff @(posedge clk_chipset) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      pcnt_q    <= '0;
      tcnt_q    <= '0;
      bcnt_q    <= '0;
      data_q    <= '0;
      par_q     <= 1'b0;
      clk_oe_q  <= 1'b0;
      data_oe_q <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      ck_sync_q <= '1;
      dt_sync_q <= '1;
    end else begin
      state_q   <= state_d;
      pcnt_q    <= pcnt_d;
      tcnt_q    <= tcnt_d;
      bcnt_q    <= bcnt_d;
      data_q    <= data_d;
      par_q     <= par_d;
      clk_oe_q  <= clk_oe_d;
      data_oe_q <= data_oe_d;
      done_q    <= done_d;
      err_q     <= err_d;
      ck_sync_q <= {ck_sync_q[1:0], ps2_clk_in};
      dt_sync_q <= {dt_sync_q[0], ps2_data_in};
    end
  end

  assign tx_ready    = (state_q == S_IDLE);
  assign busy        = (state_q != S_IDLE);
  assign done        = done_q;
  assign err         = err_q;
  assign ps2_clk_oe  = clk_oe_q;
  assign ps2_data_oe = data_oe_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// tb_ps2_host_tx: directed bench with a PS/2 device model on an
// open-drain bus and a phase-based model of the host's line behaviour.
module tb_ps2_host_tx;

  localparam int INH = 10;
  localparam int RQ  = 4;
  localparam int TO  = 2000;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready, busy, done, err;
  logic       ps2_clk_oe, ps2_data_oe;
  logic       dev_clk = 1'b1;
  logic       dev_data = 1'b1;
  logic       clk_line, data_line;

  always #5 clk = ~clk;

  assign clk_line  = dev_clk & ~ps2_clk_oe;
  assign data_line = dev_data & ~ps2_data_oe;

  ps2_host_tx #(
    .INHIBIT_CYCLES(INH),
    .REQ_CYCLES(RQ),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk_chipset(clk),
    .rst_n(rst_n),
    .tx_data(tx_data),
    .tx_valid(tx_valid),
    .tx_ready(tx_ready),
    .busy(busy),
    .done(done),
    .err(err),
    .ps2_clk_in(clk_line),
    .ps2_data_in(data_line),
    .ps2_clk_oe(ps2_clk_oe),
    .ps2_data_oe(ps2_data_oe)
  );

  int nvec = 0;
  int nfail = 0;

  task automatic chk(input string nm, input logic [31:0] a,
                     input logic [31:0] e);
    nvec++;
    if (a !== e) begin
      nfail++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, a, e, $time);
    end
  endtask

  function automatic logic [9:0] frame(input logic [7:0] d);
    return {1'b1, ~^d, d};
  endfunction

  // model: transfer active from accept until a done/err end event
  bit         chk_en = 1'b0;
  bit         act_m = 1'b0;
  int         ph = 0;
  logic [7:0] lat_m = 8'h00;
  int         n_end = 0;
  int         seen_end = 0;
  int         n_done = 0;
  int         n_err = 0;
  int         end_ph = -1;

  always @(posedge clk) begin
    if (!rst_n) begin
      act_m    = 1'b0;
      ph       = 0;
      seen_end = n_end;
    end else begin
      if (act_m && seen_end != n_end) begin
        act_m    = 1'b0;
        seen_end = n_end;
      end
      if (act_m) ph++;
      else if (tx_valid) begin
        act_m = 1'b1;
        ph    = 0;
        lat_m = tx_data;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      if (act_m && seen_end == n_end && (done || err)) begin
        chk("end_lines", {busy, tx_ready, ps2_clk_oe, ps2_data_oe},
            4'b0100);
        chk("done_err_excl", done & err, 1'b0);
        if (done) n_done++;
        if (err) n_err++;
        end_ph = ph;
        n_end++;
      end else if (act_m && seen_end == n_end) begin
        chk("busy", {busy, tx_ready}, 2'b10);
        if (ph < INH)
          chk("inhibit", {ps2_clk_oe, ps2_data_oe}, 2'b10);
        else if (ph < INH + RQ)
          chk("request", {ps2_clk_oe, ps2_data_oe}, 2'b11);
        else if (ph == INH + RQ)
          chk("release", {ps2_clk_oe, ps2_data_oe}, 2'b01);
        else
          chk("clk_rel", ps2_clk_oe, 1'b0);
      end else if (!act_m) begin
        chk("idle", {busy, tx_ready, ps2_clk_oe, ps2_data_oe, done, err},
            6'b010000);
      end
    end
  end

  task automatic send(input logic [7:0] d);
    @(posedge clk); #1;
    tx_data  = d;
    tx_valid = 1'b1;
    @(posedge clk); #1;
    tx_valid = 1'b0;
  endtask

  task automatic dev_frame(input int nfe, input bit ack,
                           output logic [9:0] got);
    int t;
    got = '0;
    t = 0;
    while (!(clk_line === 1'b1 && data_line === 1'b0) && t < 400) begin
      @(posedge clk); #1;
      t++;
    end
    chk("req_seen", (t < 400), 1'b1);
    for (int i = 0; i < nfe; i++) begin
      repeat (20) @(posedge clk);
      #1 dev_clk = 1'b0;
      repeat (20) @(posedge clk);
      #1;
      if (i < 10) got[i] = data_line;
      dev_clk = 1'b1;
      if (i == 9 && ack) dev_data = 1'b0;
      if (i == 10) dev_data = 1'b1;
    end
  endtask

  task automatic wait_end(input int ne0, input int lim);
    int t;
    t = 0;
    while (n_end == ne0 && t < lim) begin
      @(negedge clk); #1;
      t++;
    end
    chk("end_seen", (n_end != ne0), 1'b1);
  endtask

  logic [9:0] got;
  int d0, e0, ne0;

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish want finish");
    $fatal(1);
  end

  initial begin
    rst_n    = 1'b0;
    tx_valid = 1'b0;
    tx_data  = 8'h00;
    repeat (3) @(posedge clk);
    #1 chk_en = 1'b1;
    @(negedge clk);
    chk("rst_state",
        {busy, tx_ready, ps2_clk_oe, ps2_data_oe, done, err}, 6'b010000);
    @(posedge clk); #1 rst_n = 1'b1;
    repeat (3) @(posedge clk);

    // 0xED with ACK
    d0 = n_done; e0 = n_err; ne0 = n_end;
    send(8'hED);
    dev_frame(11, 1'b1, got);
    wait_end(ne0, 100);
    chk("ed_frame_model", got, frame(lat_m));
    chk("ed_frame_lit", got, 10'h3ED);
    chk("ed_done", n_done - d0, 1);
    chk("ed_err", n_err - e0, 0);
    repeat (5) @(posedge clk);

    // 0x01 with NACK
    d0 = n_done; e0 = n_err; ne0 = n_end;
    send(8'h01);
    dev_frame(11, 1'b0, got);
    wait_end(ne0, 100);
    chk("01_frame_model", got, frame(lat_m));
    chk("01_frame_lit", got, 10'h201);
    chk("01_done", n_done - d0, 0);
    chk("01_err", n_err - e0, 1);
    repeat (5) @(posedge clk);

    // 0xFF, silent device: timeout
    d0 = n_done; e0 = n_err; ne0 = n_end;
    send(8'hFF);
    wait_end(ne0, TO + 100);
    chk("to_phase", end_ph, INH + RQ + TO);
    chk("to_err", n_err - e0, 1);
    chk("to_done", n_done - d0, 0);
    repeat (5) @(posedge clk);

    // 0xF4 reset after fe 5, then a clean 0xF4
    d0 = n_done; e0 = n_err;
    send(8'hF4);
    dev_frame(5, 1'b0, got);
    chk("f4_partial", got[4:0], 5'h14);
    rst_n = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    chk("rst_mid", {ps2_clk_oe, ps2_data_oe, tx_ready}, 3'b001);
    chk("rst_mid_pulses", {n_done - d0, n_err - e0}, 64'd0);
    repeat (5) @(posedge clk);
    d0 = n_done; e0 = n_err; ne0 = n_end;
    send(8'hF4);
    dev_frame(11, 1'b1, got);
    wait_end(ne0, 100);
    chk("f4_frame_model", got, frame(lat_m));
    chk("f4_frame_lit", got, 10'h2F4);
    chk("f4_done", n_done - d0, 1);
    chk("f4_err", n_err - e0, 0);
    repeat (5) @(posedge clk);

    // 0xED with 0xAA held valid throughout
    d0 = n_done; e0 = n_err; ne0 = n_end;
    @(posedge clk); #1;
    tx_data  = 8'hED;
    tx_valid = 1'b1;
    @(posedge clk); #1;
    tx_data  = 8'hAA;
    dev_frame(11, 1'b1, got);
    wait_end(ne0, 100);
    chk("hold_ed_lit", got, 10'h3ED);
    chk("hold_ed_done", n_done - d0, 1);
    d0 = n_done; e0 = n_err; ne0 = n_end;
    @(posedge clk); #1;
    tx_valid = 1'b0;
    dev_frame(11, 1'b1, got);
    wait_end(ne0, 100);
    chk("hold_aa_model", got, frame(lat_m));
    chk("hold_aa_lit", got, 10'h3AA);
    chk("hold_aa_par", got[8], 1'b1);
    chk("hold_aa_done", n_done - d0, 1);
    chk("hold_aa_err", n_err - e0, 0);
    repeat (10) @(posedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
